// File: rtl/lift_pkg.sv
// Shared definitions for the lift controller: floor-bus defaults, display
// digit encodings, controller state encoding and key debouncer states.
package lift_pkg;

  localparam int unsigned N_FLOORS_DEF  = 9;
  localparam int unsigned FLOOR_W_DEF   = 4;
  localparam int unsigned DEBOUNCE_DEF  = 1000000;

  // Controller motion states; the controller drives lift_idle from PARADO
  typedef enum logic [1:0] {
    PARADO   = 2'd0,
    SUBINDO  = 2'd1,
    DESCENDO = 2'd2
  } lift_state_e;

  typedef enum logic {
    DB_STABLE   = 1'b0,
    DB_CHANGING = 1'b1
  } db_state_e;

  function automatic logic is_idle(input lift_state_e s);
    return s == PARADO;
  endfunction

  // Active-low 7-segment patterns {g,f,e,d,c,b,a} for decimal digits
  function automatic logic [6:0] seg7_digit(input logic [3:0] d);
    logic [6:0] seg;
    case (d)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronises and debounces an active-low push button and emits one pulse
// per accepted press; a key held through reset must be released first.
module key_debounce
  import lift_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_key_n,
  output logic o_press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  db_state_e        r_state;
  db_state_e        w_state_nxt;
  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_level;
  logic             w_level_nxt;
  logic             r_armed;
  logic             w_armed_nxt;
  logic             r_press;
  logic             w_press_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_state <= DB_STABLE;
      r_cnt   <= '0;
      r_level <= 1'b1;
      r_armed <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
      r_armed <= w_armed_nxt;
      r_press <= w_press_nxt;
    end
  end

  // While disarmed the counter instead times a steady release, which arms presses
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_level_nxt = r_level;
    w_armed_nxt = r_armed;
    w_press_nxt = 1'b0;
    case (r_state)
      DB_STABLE: begin
        if (r_sync2 != r_level) begin
          w_state_nxt = DB_CHANGING;
          w_cnt_nxt   = '0;
        end else if (!r_armed && r_level) begin
          if (r_cnt == CNT_LAST) begin
            w_armed_nxt = 1'b1;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end else begin
          w_cnt_nxt = '0;
        end
      end
      DB_CHANGING: begin
        if (r_sync2 == r_level) begin
          w_state_nxt = DB_STABLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = DB_STABLE;
          w_cnt_nxt   = '0;
          w_level_nxt = r_sync2;
          w_press_nxt = r_armed && !r_sync2;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = DB_STABLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_press = r_press;

endmodule

// File: rtl/lift_request_queue.sv
// Turns debounced floor-button presses into a pending-call bitmap and picks
// the next target floor with SCAN ordering.
module lift_request_queue
  import lift_pkg::*;
#(
  parameter int unsigned N_FLOORS        = N_FLOORS_DEF,
  parameter int unsigned FLOOR_W         = FLOOR_W_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic                CLOCK_50,
  input  logic                RESET,
  input  logic [N_FLOORS-1:0] SW,
  input  logic                KEY0,
  input  logic [FLOOR_W-1:0]  cur_floor,
  input  logic                lift_idle,
  input  logic                arrive,
  output logic [FLOOR_W-1:0]  target_floor,
  output logic                target_valid,
  output logic                dir_up,
  output logic [N_FLOORS-1:0] pending,
  output logic                req_accept,
  output logic                req_error
);

  logic                w_press;
  logic                w_sw_onehot;
  logic [FLOOR_W-1:0]  w_sw_floor;
  logic                w_served_here;
  logic [N_FLOORS-1:0] w_set;
  logic [N_FLOORS-1:0] w_clr;
  logic [N_FLOORS-1:0] w_pending_nxt;
  logic                w_above;
  logic                w_below;
  logic                w_here;
  logic [FLOOR_W-1:0]  w_lo_above;
  logic [FLOOR_W-1:0]  w_hi_below;
  logic [FLOOR_W-1:0]  w_tgt_nxt;
  logic                w_valid_nxt;
  logic                w_dir_nxt;

  logic [N_FLOORS-1:0] r_pending;
  logic [FLOOR_W-1:0]  r_tgt;
  logic                r_valid;
  logic                r_dir;
  logic                r_accept;
  logic                r_error;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key (
    .clk    (CLOCK_50),
    .rst    (RESET),
    .i_key_n(KEY0),
    .o_press(w_press)
  );

  assign w_sw_onehot = (SW != '0) && ((SW & (SW - N_FLOORS'(1))) == '0);

  always_comb begin
    w_sw_floor = '0;
    for (int unsigned i = 0; i < N_FLOORS; i++) begin
      if (SW[i]) w_sw_floor = FLOOR_W'(i);
    end
  end

  // A press for the floor the stopped lift is already at needs no call
  assign w_served_here = lift_idle && (w_sw_floor == cur_floor);

  always_comb begin
    w_set = (w_press && w_sw_onehot && !w_served_here) ? SW : '0;
    w_clr = '0;
    for (int unsigned i = 0; i < N_FLOORS; i++) begin
      w_clr[i] = arrive && (32'(cur_floor) == i);
    end
    w_pending_nxt = (r_pending | w_set) & ~w_clr;
  end

  // Nearest pending floor on each side of the current floor
  always_comb begin
    w_above    = 1'b0;
    w_below    = 1'b0;
    w_here     = 1'b0;
    w_lo_above = '0;
    w_hi_below = '0;
    for (int unsigned i = 0; i < N_FLOORS; i++) begin
      if (r_pending[i]) begin
        if (i > 32'(cur_floor)) begin
          if (!w_above) w_lo_above = FLOOR_W'(i);
          w_above = 1'b1;
        end
        if (i < 32'(cur_floor)) begin
          w_hi_below = FLOOR_W'(i);
          w_below    = 1'b1;
        end
        if (i == 32'(cur_floor)) w_here = 1'b1;
      end
    end
  end

  always_comb begin
    w_dir_nxt   = r_dir;
    w_tgt_nxt   = r_tgt;
    w_valid_nxt = 1'b0;
    if (r_dir) begin
      if (w_above) begin
        w_tgt_nxt   = w_lo_above;
        w_valid_nxt = 1'b1;
      end else if (w_below) begin
        w_dir_nxt   = 1'b0;
        w_tgt_nxt   = w_hi_below;
        w_valid_nxt = 1'b1;
      end else if (w_here) begin
        w_tgt_nxt   = cur_floor;
        w_valid_nxt = 1'b1;
      end
    end else begin
      if (w_below) begin
        w_tgt_nxt   = w_hi_below;
        w_valid_nxt = 1'b1;
      end else if (w_above) begin
        w_dir_nxt   = 1'b1;
        w_tgt_nxt   = w_lo_above;
        w_valid_nxt = 1'b1;
      end else if (w_here) begin
        w_tgt_nxt   = cur_floor;
        w_valid_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_pending <= '0;
      r_tgt     <= '0;
      r_valid   <= 1'b0;
      r_dir     <= 1'b1;
      r_accept  <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      r_tgt     <= w_tgt_nxt;
      r_valid   <= w_valid_nxt;
      r_dir     <= w_dir_nxt;
      r_accept  <= w_press && w_sw_onehot;
      r_error   <= w_press && !w_sw_onehot;
    end
  end

  assign pending      = r_pending;
  assign target_floor = r_tgt;
  assign target_valid = r_valid;
  assign dir_up       = r_dir;
  assign req_accept   = r_accept;
  assign req_error    = r_error;

endmodule

// File: tb/tb_lift_request_queue.sv
// Directed and randomized checks of lift_request_queue against a
// queue-based model of the call list and SCAN rules.
module tb_lift_request_queue;

  localparam int unsigned NF = 9;
  localparam int unsigned FW = 4;
  localparam int unsigned DC = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [NF-1:0] sw;
  logic          key;
  logic [FW-1:0] cur;
  logic          idle;
  logic          arrive;
  logic [FW-1:0] target_floor;
  logic          target_valid;
  logic          dir_up;
  logic [NF-1:0] pending;
  logic          req_accept;
  logic          req_error;

  always #5 clk = ~clk;

  lift_request_queue #(
    .N_FLOORS(NF), .FLOOR_W(FW), .DEBOUNCE_CYCLES(DC)
  ) dut (
    .CLOCK_50(clk), .RESET(rst), .SW(sw), .KEY0(key), .cur_floor(cur),
    .lift_idle(idle), .arrive(arrive), .target_floor(target_floor),
    .target_valid(target_valid), .dir_up(dir_up), .pending(pending),
    .req_accept(req_accept), .req_error(req_error)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int acc_cnt = 0;
  int err_cnt = 0;

  // Model: outstanding calls as a set of floor numbers
  int m_q[$];
  int m_cur;
  bit m_idle;
  bit m_dir;
  int m_tgt;
  bit m_valid;

  task automatic tick();
    @(posedge clk);
    #1;
    acc_cnt += int'(req_accept);
    err_cnt += int'(req_error);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    m_q.delete();
    m_dir   = 1'b1;
    m_tgt   = 0;
    m_valid = 1'b0;
  endfunction

  function automatic void m_add(input int f);
    foreach (m_q[k]) if (m_q[k] == f) return;
    m_q.push_back(f);
  endfunction

  function automatic void m_clear(input int f);
    int keep[$];
    foreach (m_q[k]) if (m_q[k] != f) keep.push_back(m_q[k]);
    m_q = keep;
  endfunction

  function automatic logic [NF-1:0] m_bitmap();
    logic [NF-1:0] b = '0;
    foreach (m_q[k]) b[m_q[k]] = 1'b1;
    return b;
  endfunction

  // SCAN choice: nearest call ahead, else turn around to nearest call behind
  function automatic void m_step();
    int nearest_up = 0;
    int nearest_dn = 0;
    bit has_up = 1'b0;
    bit has_dn = 1'b0;
    foreach (m_q[k]) begin
      if (m_q[k] > m_cur && (!has_up || m_q[k] < nearest_up)) begin
        nearest_up = m_q[k];
        has_up = 1'b1;
      end
      if (m_q[k] < m_cur && (!has_dn || m_q[k] > nearest_dn)) begin
        nearest_dn = m_q[k];
        has_dn = 1'b1;
      end
    end
    m_valid = (m_q.size() != 0);
    if (!m_valid) return;
    if (m_dir) begin
      if (has_up) m_tgt = nearest_up;
      else if (has_dn) begin m_dir = 1'b0; m_tgt = nearest_dn; end
      else m_tgt = m_cur;
    end else begin
      if (has_dn) m_tgt = nearest_dn;
      else if (has_up) begin m_dir = 1'b1; m_tgt = nearest_up; end
      else m_tgt = m_cur;
    end
  endfunction

  task automatic check_state(input string tag);
    check({tag, ".pending"}, 32'(pending), 32'(m_bitmap()));
    check({tag, ".valid"}, 32'(target_valid), 32'(m_valid));
    check({tag, ".dir_up"}, 32'(dir_up), 32'(m_dir));
    if (m_valid) check({tag, ".target"}, 32'(target_floor), 32'(m_tgt));
    else check({tag, ".target_hold"}, 32'(target_floor), 32'(m_tgt));
  endtask

  task automatic set_floor(input int f, input bit idl);
    cur    = FW'(f);
    idle   = idl;
    m_cur  = f;
    m_idle = idl;
    repeat (3) tick();
    m_step();
  endtask

  // Clean press/release of KEY0; optionally holds arrive for the whole press
  task automatic press(input logic [NF-1:0] s, input bit hold_arrive, input string tag);
    int f;
    bit exp_acc;
    sw      = s;
    acc_cnt = 0;
    err_cnt = 0;
    arrive  = hold_arrive;
    key     = 1'b0;
    repeat (20) tick();
    arrive  = 1'b0;
    key     = 1'b1;
    repeat (20) tick();
    if (hold_arrive) begin
      m_clear(m_cur);
      m_step();
    end
    exp_acc = ($countones(s) == 1);
    if (exp_acc) begin
      f = 0;
      for (int i = 0; i < int'(NF); i++) if (s[i]) f = i;
      if (!(f == m_cur && m_idle)) m_add(f);
      if (hold_arrive) m_clear(m_cur);
    end
    m_step();
    check({tag, ".accepts"}, 32'(acc_cnt), exp_acc ? 32'd1 : 32'd0);
    check({tag, ".errors"}, 32'(err_cnt), exp_acc ? 32'd0 : 32'd1);
    check_state(tag);
  endtask

  task automatic do_arrive(input string tag);
    arrive = 1'b1;
    tick();
    arrive = 1'b0;
    repeat (3) tick();
    if (m_cur < int'(NF)) m_clear(m_cur);
    m_step();
    check_state(tag);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; key = 1'b0; sw = '0; cur = '0; idle = 1'b0; arrive = 1'b0;
    m_cur = 0; m_idle = 1'b0;
    m_reset();

    // Reset with KEY0 held low
    repeat (3) tick();
    check("reset.pending", 32'(pending), 32'd0);
    check("reset.valid", 32'(target_valid), 32'd0);
    check("reset.dir_up", 32'(dir_up), 32'd1);
    check("reset.target", 32'(target_floor), 32'd0);
    check("reset.accept", 32'(req_accept), 32'd0);
    check("reset.error", 32'(req_error), 32'd0);
    rst = 1'b0;
    acc_cnt = 0; err_cnt = 0;
    repeat (20) tick();
    check("held_after_reset.accepts", 32'(acc_cnt), 32'd0);
    check("held_after_reset.errors", 32'(err_cnt), 32'd0);
    check("held_after_reset.pending", 32'(pending), 32'd0);
    key = 1'b1;
    repeat (20) tick();

    // Bouncing key, then a clean hold: one accept, target one cycle later
    sw = 9'b000010000;
    set_floor(0, 1'b0);
    acc_cnt = 0; err_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      key = (k % 2 == 0) ? 1'b0 : 1'b1;
      repeat (3) tick();
    end
    key = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      tick();
      if (req_accept) seen = 1'b1;
    end
    check("bounce.accept_seen", 32'(seen), 32'd1);
    check("bounce.pending_at_accept", 32'(pending), 32'h010);
    check("bounce.valid_at_accept", 32'(target_valid), 32'd0);
    tick();
    check("bounce.valid_next", 32'(target_valid), 32'd1);
    check("bounce.target_next", 32'(target_floor), 32'd4);
    repeat (12) tick();
    key = 1'b1;
    repeat (20) tick();
    check("bounce.accepts", 32'(acc_cnt), 32'd1);
    check("bounce.errors", 32'(err_cnt), 32'd0);
    m_add(4);
    m_step();
    check_state("bounce");

    press(9'b000000110, 1'b0, "invalid_sw");
    press(9'b000000000, 1'b0, "zero_sw");

    set_floor(4, 1'b0);
    do_arrive("clear4");

    // SCAN ordering from floor 3 going up
    set_floor(3, 1'b0);
    press(9'b000100000, 1'b0, "scan.p5");
    press(9'b010000000, 1'b0, "scan.p7");
    press(9'b000000010, 1'b0, "scan.p1");
    check("scan.first_target", 32'(target_floor), 32'd5);
    set_floor(5, 1'b0);
    do_arrive("scan.arr5");
    check("scan.second_target", 32'(target_floor), 32'd7);
    set_floor(7, 1'b0);
    do_arrive("scan.arr7");
    check("scan.reverse_dir", 32'(dir_up), 32'd0);
    check("scan.reverse_target", 32'(target_floor), 32'd1);
    set_floor(1, 1'b0);
    do_arrive("scan.arr1");

    // Press at the stopped lift's floor, then press during arrive
    set_floor(2, 1'b1);
    press(9'b000000100, 1'b0, "same_floor");
    check("same_floor.pending_empty", 32'(pending), 32'd0);
    press(9'b001000000, 1'b1, "press_with_arrive");
    check("press_with_arrive.pending", 32'(pending), 32'h040);
    set_floor(6, 1'b0);
    press(9'b001000000, 1'b1, "clear_wins");
    check("clear_wins.pending", 32'(pending), 32'd0);

    // Boundary floors
    set_floor(8, 1'b0);
    press(9'b000000001, 1'b0, "top_floor");
    set_floor(0, 1'b0);
    press(9'b100000000, 1'b0, "bottom_floor");
    set_floor(12, 1'b0);
    do_arrive("arrive_out_of_range");

    // Reset in the middle of a debounce with the key still held
    key = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    m_reset();
    acc_cnt = 0; err_cnt = 0;
    repeat (20) tick();
    check("mid_debounce_reset.accepts", 32'(acc_cnt), 32'd0);
    check("mid_debounce_reset.pending", 32'(pending), 32'd0);
    key = 1'b1;
    repeat (20) tick();
    set_floor(2, 1'b0);
    press(9'b000001000, 1'b0, "after_reset_press");

    // Randomized presses and arrivals
    for (int it = 0; it < 40; it++) begin
      logic [NF-1:0] s;
      if ($urandom_range(0, 2) != 2) begin
        set_floor(int'($urandom_range(0, 10)), 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 3) != 0) s = NF'(1) << $urandom_range(0, NF - 1);
        else s = NF'($urandom);
        press(s, $urandom_range(0, 4) == 0, "rand.press");
      end else begin
        set_floor(int'($urandom_range(0, 11)), 1'($urandom_range(0, 1)));
        do_arrive("rand.arrive");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lift_request_queue.md
Name: lift_request_queue

Overview:
- Upstream stage of the lift controller: turns raw panel inputs (one-hot floor switches SW, push-button KEY0) into a queue of pending floor calls.
- Presents a single scheduled target floor to the controller using SCAN ordering: keep serving in the current direction, reverse only when nothing remains ahead.
- Clears a call when the controller reports arrival at that floor.
- Lets the controller accept new calls while moving instead of latching one floor per button edge.

Parameters:
- N_FLOORS, 9, number of floors (0..N_FLOORS-1); width of SW and pending.
- FLOOR_W, 4, width of floor-number buses.
- DEBOUNCE_CYCLES, 1000000, CLOCK_50 cycles KEY0 must hold steady before a level change is accepted (20 ms at 50 MHz).

Ports:
- CLOCK_50 input 1: system clock, all logic on rising edge.
- RESET input 1: synchronous, active-high reset.
- SW input N_FLOORS: floor selection, one-hot, sampled at press event.
- KEY0 input 1: raw request button, active-low, asynchronous to CLOCK_50.
- cur_floor input FLOOR_W: controller's current floor.
- lift_idle input 1: 1 when the controller is stopped (door-open state).
- arrive input 1: one-cycle pulse; the controller has stopped at cur_floor.
- target_floor output FLOOR_W: scheduled next floor.
- target_valid output 1: 1 when any call is pending.
- dir_up output 1: current SCAN direction (1 up, 0 down).
- pending output N_FLOORS: bitmap of outstanding calls.
- req_accept output 1: one-cycle pulse for a valid press.
- req_error output 1: one-cycle pulse for a press with SW not one-hot.

Behaviour:
- Reset values: pending=0, target_floor=0, target_valid=0, dir_up=1, req_accept=0, req_error=0, debounced KEY level=1 (released), debounce counter=0, sync flops=1.
- KEY0 input path:
  - 2-flop synchronizer.
  - Debouncer FSM with states STABLE and CHANGING.
    - STABLE → CHANGING when the synced value differs from the debounced level; the counter loads 0.
    - In CHANGING the counter increments while the synced value stays different.
    - If the synced value returns to the debounced level first, go back to STABLE with no change.
    - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level takes the new value; go to STABLE.
- Press event: the debounced level goes 1→0. It fires exactly once per press; release produces nothing.
- On a press event, SW is sampled the same cycle:
  - Exactly one bit set at floor f, and f ≠ cur_floor or lift_idle=0: set pending[f], pulse req_accept next cycle.
  - Exactly one bit set, f == cur_floor and lift_idle=1: pulse req_accept; pending is unchanged because the call is already served.
  - Zero or multiple bits set: pulse req_error; pending is unchanged.
  - Setting an already-set bit is harmless (idempotent).
- arrive with cur_floor < N_FLOORS clears pending[cur_floor].
  - arrive with cur_floor ≥ N_FLOORS is ignored.
  - A press for floor cur_floor in the same cycle as arrive: the clear wins.
  - A press for a different floor in the same cycle as arrive: both take effect.
- Scheduler (combinational on the current pending/cur_floor/dir_up, registered to outputs; 1-cycle latency from a pending change to target_floor/target_valid):
  - above = any pending bit above cur_floor; below = any pending bit below cur_floor.
  - dir_up=1: if above, target = lowest pending floor > cur_floor; else if below, dir_up←0 and target = highest pending floor < cur_floor.
  - dir_up=0: mirror image of dir_up=1.
  - Neither above nor below, but pending[cur_floor]=1: target = cur_floor.
  - Nothing pending: target_valid=0, target_floor holds its last value, dir_up holds.
  - At the boundaries: floor 0 forces nothing below, floor N_FLOORS-1 forces nothing above.
- RESET mid-press or mid-debounce: all state returns to reset values; a key still held after reset must be released and pressed again to register.
- Widths: floor indices are unsigned FLOOR_W bits; comparisons are unsigned.

Decomposition:
- Shared package lift_pkg holds:
  - N_FLOORS and FLOOR_W defaults;
  - the 7-segment digit encodings used by the display stages;
  - the controller state encoding (parado=0, subindo=1, descendo=2) so lift_idle can be derived consistently.
- One sub-module: key_debounce (synchronizer + STABLE/CHANGING FSM + press-pulse output), parameterised by DEBOUNCE_CYCLES.
- Scheduler priority search stays inline.

Test Plan:
- All tests use DEBOUNCE_CYCLES=8.
- Reset: hold RESET 3 cycles, KEY0=0 → pending=0, target_valid=0, dir_up=1, no pulses.
- Bounce: KEY0 toggles every 3 cycles for 30 cycles, then holds 0 with SW=9'b000010000 and cur_floor=0 → exactly one req_accept; pending=9'b000010000; target_floor=4, target_valid=1 one cycle later.
- Invalid SW: press with SW=9'b000000110 → req_error pulse, pending unchanged, no req_accept.
- SCAN ordering: cur_floor=3, dir_up=1, pending floors {1,5,7} → target 5. arrive at 5 → target 7. arrive at 7 → dir_up=0, target 1.
- Same-floor press: lift_idle=1, cur_floor=2, press SW=9'b000000100 → req_accept, pending stays 0. Then press floor 6 in the same cycle as arrive at cur_floor=2 → pending=9'b001000000.
- Reset mid-debounce: KEY0 low 4 cycles, RESET, KEY0 still low → no press event until released and pressed again.
